// File: rtl/transmit_fifo_pkg.sv
// ============================================================================
// transmit_fifo_pkg
// ----------------------------------------------------------------------------
// Shared sizing constants and types for the UART transmit-side byte FIFO.
//
//   DATA_W : width of one buffered byte
//   ADDR_W : pointer width; the buffer holds 2^ADDR_W entries
//   DEPTH  : number of entries (32 by default)
//
//   byte_t : one buffered byte
//   ptr_t  : read/write pointer into the storage array
//   cnt_t  : occupancy count, one bit wider than a pointer so that a
//            completely full buffer (DEPTH entries) is representable
//
// Optional feature macro: TRANSMIT_FIFO_FWFT_EN (see transmit_fifo.sv).
// ============================================================================
package transmit_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/transmit_fifo_ram.sv
// ============================================================================
// transmit_fifo_ram
// ----------------------------------------------------------------------------
// Storage array for the transmit FIFO: 2^ADDR_W x DATA_W, one synchronous
// write port and one read port. The array itself is never reset; only the
// registered read-data output (default build) has a reset value.
//
// Ports:
//   i_clk     : clock, all state updates on the rising edge
//   i_rst     : synchronous active-high reset for the read-data register
//   i_wrEn    : write strobe
//   i_wrAddr  : write address
//   i_wrData  : write data
//   i_rdEn    : read strobe (loads the read register in the default build)
//   i_rdAddr  : read address
//   o_rdData  : read data
//
// Build option TRANSMIT_FIFO_FWFT_EN:
//   defined   -> asynchronous read, o_rdData follows i_rdAddr combinationally;
//                i_rst and i_rdEn have no effect
//   undefined -> synchronous read, o_rdData loads on i_rdEn and holds
// ============================================================================
module transmit_fifo_ram
    import transmit_fifo_pkg::*;
#(
    parameter int RAM_DATA_W = DATA_W,
    parameter int RAM_ADDR_W = ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wrEn,
    input  logic [RAM_ADDR_W-1:0] i_wrAddr,
    input  logic [RAM_DATA_W-1:0] i_wrData,
    input  logic                  i_rdEn,
    input  logic [RAM_ADDR_W-1:0] i_rdAddr,
    output logic [RAM_DATA_W-1:0] o_rdData
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

    logic [RAM_DATA_W-1:0] r_mem [RAM_DEPTH];

    // Write port. The array carries no reset so it maps onto plain
    // distributed RAM; stale contents are never observable because the
    // pointer/count logic in the top level guards every read.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

`ifdef TRANSMIT_FIFO_FWFT_EN

    // First-word-fall-through: the head entry is presented combinationally
    // so the transmitter sees it as soon as the pointer settles.
    logic w_unusedRdCtl;

    assign w_unusedRdCtl = i_rst ^ i_rdEn;
    assign o_rdData      = r_mem[i_rdAddr];

`else

    logic [RAM_DATA_W-1:0] r_rdData;

    // Registered read: the byte being popped is captured on the pop edge
    // and held until the next pop. Only reset clears it; a flush leaves
    // the last transmitted byte visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

`endif

endmodule

// File: rtl/transmit_fifo.sv
// ============================================================================
// transmit_fifo
// ----------------------------------------------------------------------------
// UART transmit-side byte buffer: a 2^ADDR_W-entry circular FIFO sitting
// between the bus write path and the transmit shift engine. Bytes are pushed
// while the block is in fill mode and transmit is enabled, and popped one per
// done_tx while in drain mode. A programmable full level limits occupancy and
// rx_state_full performs a synchronous flush.
//
// Ports:
//   clk_i             : clock, all state on the rising edge
//   rst_ni            : synchronous reset, ACTIVE HIGH despite the name
//   wr_data           : byte to push
//   fifo_en           : global enable; no push or pop while low
//   ctrl_tx_buffer    : 0 = fill (push path), 1 = drain (pop path)
//   done_tx           : transmitter finished a byte; level-sampled pop request
//   TXen              : transmit enable, gates pushes
//   tx_buffer_overrun : overrun flag, blocks pushes while high
//   rx_state_full     : synchronous flush request
//   ptr_addr_wr_i     : full level; N != 0 -> full at N entries, 0 -> full
//                       at 2^ADDR_W entries
//   ptr_addr_wr_o     : current write pointer (next write address)
//   wr_data_o         : head / last popped byte for the transmitter
//
// Build option TRANSMIT_FIFO_FWFT_EN:
//   defined   -> first-word-fall-through, wr_data_o = empty ? 0 : mem[rp]
//   undefined -> wr_data_o is a register loaded with mem[rp] on each pop
// ============================================================================
module transmit_fifo
    import transmit_fifo_pkg::*;
#(
    parameter int FIFO_DATA_W = DATA_W,
    parameter int FIFO_ADDR_W = ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [FIFO_DATA_W-1:0] wr_data,
    input  logic                   fifo_en,
    input  logic                   ctrl_tx_buffer,
    input  logic                   done_tx,
    input  logic                   TXen,
    input  logic                   tx_buffer_overrun,
    input  logic                   rx_state_full,
    input  logic [FIFO_ADDR_W-1:0] ptr_addr_wr_i,
    output logic [FIFO_ADDR_W-1:0] ptr_addr_wr_o,
    output logic [FIFO_DATA_W-1:0] wr_data_o
);

    // Occupancy that corresponds to every slot in use; used when the
    // programmable full level is written as zero.
    localparam logic [FIFO_ADDR_W:0] CNT_DEPTH = {1'b1, {FIFO_ADDR_W{1'b0}}};

    logic [FIFO_ADDR_W-1:0] r_wp;
    logic [FIFO_ADDR_W-1:0] r_rp;
    logic [FIFO_ADDR_W:0]   r_count;

    logic [FIFO_ADDR_W:0]   w_limit;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ramWrEn;
    logic                   w_ramRdEn;
    logic [FIFO_DATA_W-1:0] w_ramRdData;

    // Full uses >= rather than == so that lowering the level below the
    // current occupancy blocks pushes while keeping the stored bytes.
    assign w_limit = (ptr_addr_wr_i == '0) ? CNT_DEPTH : {1'b0, ptr_addr_wr_i};
    assign w_full  = (r_count >= w_limit);
    assign w_empty = (r_count == '0);

    // Push and pop are separated by ctrl_tx_buffer, so they can never
    // both be active in the same cycle.
    assign w_push = fifo_en & TXen & ~ctrl_tx_buffer & ~tx_buffer_overrun & ~w_full;
    assign w_pop  = fifo_en & ctrl_tx_buffer & done_tx & ~w_empty;

    // A flush wins over any transfer in the same cycle, so the storage
    // strobes are suppressed as well as the pointer updates.
    assign w_ramWrEn = w_push & ~rx_state_full;
    assign w_ramRdEn = w_pop  & ~rx_state_full;

    // Pointer and occupancy bookkeeping. Reset and flush both return the
    // FIFO to empty; the pointers wrap naturally at 2^FIFO_ADDR_W.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (rx_state_full) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_wp    <= r_wp + 1'b1;
            r_count <= r_count + 1'b1;
        end else if (w_pop) begin
            r_rp    <= r_rp + 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    transmit_fifo_ram #(
        .RAM_DATA_W (FIFO_DATA_W),
        .RAM_ADDR_W (FIFO_ADDR_W)
    ) u_ram (
        .i_clk    (clk_i),
        .i_rst    (rst_ni),
        .i_wrEn   (w_ramWrEn),
        .i_wrAddr (r_wp),
        .i_wrData (wr_data),
        .i_rdEn   (w_ramRdEn),
        .i_rdAddr (r_rp),
        .o_rdData (w_ramRdData)
    );

    assign ptr_addr_wr_o = r_wp;

`ifdef TRANSMIT_FIFO_FWFT_EN
    // Mask the array output while empty so stale bytes left behind by a
    // flush are never presented to the transmitter.
    assign wr_data_o = w_empty ? '0 : w_ramRdData;
`else
    assign wr_data_o = w_ramRdData;
`endif

endmodule

// File: tb/tb_transmit_fifo.sv
// ============================================================================
// tb_transmit_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for transmit_fifo. A directed vector table covers fill,
// drain, gating and flush; hand-written sequences cover the programmable full
// level, pointer wrap and reset mid-operation; a randomized phase is checked
// against a queue-based reference model. Honours TRANSMIT_FIFO_FWFT_EN.
// ============================================================================
module tb_transmit_fifo;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] wr_data;
    logic       fifo_en;
    logic       ctrl_tx_buffer;
    logic       done_tx;
    logic       TXen;
    logic       tx_buffer_overrun;
    logic       rx_state_full;
    logic [4:0] ptr_addr_wr_i;
    logic [4:0] ptr_addr_wr_o;
    logic [7:0] wr_data_o;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: contents as a queue, write pointer as a plain
    // counter modulo 32, and the last popped byte for registered mode.
    logic [7:0] mQueue[$];
    int         mWp   = 0;
    logic [7:0] mHead = 8'd0;

    typedef struct {
        logic       en;
        logic       tx;
        logic       ctrl;
        logic       done;
        logic       ovr;
        logic       flush;
        logic [7:0] wdata;
        logic [4:0] expPtr;
        logic [7:0] expReg;
        logic [7:0] expFwft;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    transmit_fifo dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .wr_data           (wr_data),
        .fifo_en           (fifo_en),
        .ctrl_tx_buffer    (ctrl_tx_buffer),
        .done_tx           (done_tx),
        .TXen              (TXen),
        .tx_buffer_overrun (tx_buffer_overrun),
        .rx_state_full     (rx_state_full),
        .ptr_addr_wr_i     (ptr_addr_wr_i),
        .ptr_addr_wr_o     (ptr_addr_wr_o),
        .wr_data_o         (wr_data_o)
    );

    // Expected head byte according to the model for the active build.
    function automatic logic [7:0] expData();
`ifdef TRANSMIT_FIFO_FWFT_EN
        return (mQueue.size() > 0) ? mQueue[0] : 8'd0;
`else
        return mHead;
`endif
    endfunction

    // Compare both outputs against expected values.
    task automatic checkOutput(input string name, input logic [4:0] expPtr,
                               input logic [7:0] expD);
        checkCount++;
        if (ptr_addr_wr_o !== expPtr) begin
            failCount++;
            $display("[TB] FAIL %s ptr_addr_wr_o got %0d expected %0d", name, ptr_addr_wr_o, expPtr);
        end
        checkCount++;
        if (wr_data_o !== expD) begin
            failCount++;
            $display("[TB] FAIL %s wr_data_o got %0d expected %0d", name, wr_data_o, expD);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the specification's
    // rules, then wait for the edge and settle 1 time unit past it.
    task automatic applyStimulus(input logic en, input logic tx, input logic ctrl,
                                 input logic done, input logic ovr, input logic flush,
                                 input logic [4:0] level, input logic [7:0] wd);
        int limit;
        fifo_en           = en;
        TXen              = tx;
        ctrl_tx_buffer    = ctrl;
        done_tx           = done;
        tx_buffer_overrun = ovr;
        rx_state_full     = flush;
        ptr_addr_wr_i     = level;
        wr_data           = wd;
        limit = (level == 5'd0) ? 32 : int'(level);
        if (flush) begin
            mQueue.delete();
            mWp = 0;
        end else if (en && tx && !ctrl && !ovr && mQueue.size() < limit) begin
            mQueue.push_back(wd);
            mWp = (mWp + 1) % 32;
        end else if (en && ctrl && done && mQueue.size() > 0) begin
            mHead = mQueue.pop_front();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyReset();
        rst_ni            = 1'b1;
        fifo_en           = 1'b0;
        TXen              = 1'b0;
        ctrl_tx_buffer    = 1'b0;
        done_tx           = 1'b0;
        tx_buffer_overrun = 1'b0;
        rx_state_full     = 1'b0;
        ptr_addr_wr_i     = 5'd0;
        wr_data           = 8'd0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        mQueue.delete();
        mWp   = 0;
        mHead = 8'd0;
    endtask

    initial begin
        logic [7:0] rowExp;
        logic [4:0] expPtr;
        logic       ctrlR;
        logic [4:0] levelR;

        // Directed vectors, starting from reset with full level 0 (32).
        //            en    tx    ctrl  done  ovr   flush wdata  ptr    reg     fwft
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10, 5'd1, 8'd0,  8'd10});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20, 5'd2, 8'd0,  8'd10});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30, 5'd3, 8'd0,  8'd10});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  5'd3, 8'd0,  8'd10});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  5'd3, 8'd10, 8'd20});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  5'd3, 8'd10, 8'd20});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd40, 5'd3, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd40, 5'd4, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 5'd5, 8'd20, 8'd30});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0,  5'd0, 8'd20, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  5'd0, 8'd20, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd60, 5'd1, 8'd20, 8'd60});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  5'd1, 8'd20, 8'd60});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  5'd1, 8'd60, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  5'd1, 8'd60, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd70, 5'd0, 8'd60, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd80, 5'd1, 8'd60, 8'd80});

        applyReset();
        checkOutput("reset", 5'd0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].tx, vecs[i].ctrl, vecs[i].done,
                          vecs[i].ovr, vecs[i].flush, 5'd0, vecs[i].wdata);
`ifdef TRANSMIT_FIFO_FWFT_EN
            rowExp = vecs[i].expFwft;
`else
            rowExp = vecs[i].expReg;
`endif
            checkOutput($sformatf("vec%0d", i), vecs[i].expPtr, rowExp);
        end

        // Full level of 4: six pushes, only four land.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 8'd0);
        checkOutput("lvl4_flush", 5'd0, expData());
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'(100 + i));
            expPtr = (i < 4) ? 5'(i + 1) : 5'd4;
            checkOutput($sformatf("lvl4_push%0d", i), expPtr, expData());
        end

        // Lowering the level below the occupancy blocks pushes, keeps data.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'd99);
        checkOutput("lvl_lowered", 5'd4, expData());

        // Full level 0 means 32 entries: pointer wraps, 33rd push dropped.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0);
        checkOutput("lvl0_flush", 5'd0, expData());
        for (int i = 0; i < 33; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'(i + 1));
            expPtr = 5'((i < 32) ? (i + 1) % 32 : 0);
            checkOutput($sformatf("lvl0_push%0d", i), expPtr, expData());
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        checkOutput("lvl0_pop", 5'd0, expData());

        // Reset in the middle of operation clears pointers and output.
        applyReset();
        checkOutput("reset_midop", 5'd0, 8'd0);

        // Randomized phase: fill/drain alternates in bursts, the full level
        // changes occasionally, flush and overrun fire rarely.
        ctrlR  = 1'b0;
        levelR = 5'd0;
        for (int c = 0; c < 1000; c++) begin
            if (c % 16 == 0) ctrlR = 1'($urandom_range(0, 1));
            if (c % 50 == 0) levelR = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, ctrlR,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 59) == 0, levelR, 8'($urandom));
            checkOutput($sformatf("rand%0d", c), 5'(mWp), expData());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/transmit_fifo.md
# transmit_fifo

UART transmit-side byte buffer: 32 × 8-bit circular FIFO between the register/bus write path and the transmit shift engine. Bytes are pushed by the bus while transmit is enabled and popped one per `done_tx` when the transmitter is in buffer mode. The FIFO exports its write pointer and head byte, and supports a programmable full level and a synchronous flush.

## Interface
- `DATA_W`, default 8: byte width.
- `ADDR_W`, default 5: pointer width; depth = 2^ADDR_W = 32.
- `clk_i` in, 1: single clock, all state on rising edge.
- `rst_ni` in, 1: synchronous, active-high reset. The name follows codebase convention, but the polarity is high.
- `wr_data` in, DATA_W: byte to push.
- `fifo_en` in, 1: global FIFO enable; no push or pop when low.
- `ctrl_tx_buffer` in, 1: mode select. 0 = fill (push path), 1 = drain (pop path).
- `done_tx` in, 1: transmitter finished a byte; level-sampled pop request.
- `TXen` in, 1: transmit enable; gates pushes.
- `tx_buffer_overrun` in, 1: overrun flag asserted; blocks pushes while high.
- `rx_state_full` in, 1: synchronous flush request.
- `ptr_addr_wr_i` in, ADDR_W: programmable full level. Value N≠0 means full at N entries; 0 means full at 32.
- `ptr_addr_wr_o` out, ADDR_W: current write pointer (next write address).
- `wr_data_o` out, DATA_W: head byte for the transmitter.

## Operation
- State: `mem[32]`, write pointer `wp`, read pointer `rp` (ADDR_W each), and `count` (ADDR_W+1 bits, 0..32).
- `full` = (`count` == (`ptr_addr_wr_i`==0 ? 32 : `ptr_addr_wr_i`)) or (`count` ≥ that limit).
- `empty` = (`count` == 0).
- Push = `fifo_en` & `TXen` & !`ctrl_tx_buffer` & !`tx_buffer_overrun` & !`full`.
  - Writes `mem[wp]` ← `wr_data`.
  - `wp` += 1, wrapping 31→0.
  - `count` += 1.
- Pop = `fifo_en` & `ctrl_tx_buffer` & `done_tx` & !`empty`.
  - `rp` += 1 (wrapping), `count` −= 1.
- Push and pop are mutually exclusive by `ctrl_tx_buffer`; no simultaneous case exists.
- Push when full: silently dropped. Pop when empty: ignored. State is unchanged in both cases.
- Priority: `rst_ni` > `rx_state_full` > push/pop.
  - Flush zeroes `wp`, `rp` and `count`.
  - `mem` is not cleared.
  - Any push or pop in the flush cycle is discarded.
- `done_tx` held high pops once per cycle until empty.
- `ptr_addr_wr_o` = `wp` directly (registered).
- Lowering the full level below the current `count` blocks further pushes; existing data is kept.

## Timing
- Reset values:
  - `wp`, `rp`, `count` = 0.
  - `ptr_addr_wr_o` = 0.
  - `wr_data_o` = 0.
  - `mem` is not reset.
- Push: `ptr_addr_wr_o` reflects the increment one cycle after the sampling edge.
- Pop/head latency: see Configuration.
- Flush: pointers read 0 on the cycle after `rx_state_full` is sampled high.
- Reset mid-operation: same as flush; additionally `wr_data_o` returns to 0.

## Configuration
- `TRANSMIT_FIFO_FWFT_EN` defined: first-word-fall-through.
  - `wr_data_o` = `empty` ? 0 : `mem[rp]`, combinational from registered state.
  - The head byte is valid the cycle after the push that made the FIFO non-empty.
  - After a pop, the next byte appears the cycle after the pop edge.
- Undefined (default): registered read.
  - `wr_data_o` register loads `mem[rp]` on each pop edge and holds otherwise.
  - The popped byte is visible the cycle after `done_tx`.
  - The register is cleared by reset only; flush does not clear it.

## Structure
- Package `transmit_fifo_pkg`: `DATA_W`=8, `ADDR_W`=5, `DEPTH`=32, `byte_t`, `ptr_t`, `cnt_t` (ADDR_W+1 bits).
- Sub-module `transmit_fifo_ram`: 32×8 storage with 1 synchronous write port and 1 read port.
  - Read port is asynchronous when `TRANSMIT_FIFO_FWFT_EN` is defined, synchronous with enable otherwise.
- Top level holds pointers, count, full/empty, priority logic and the output mux.

## Test plan
- Reset: assert `rst_ni`=1 one cycle, then release -> `ptr_addr_wr_o`=0, `wr_data_o`=0.
- Fill: `TXen`=1, `fifo_en`=1, `ctrl_tx_buffer`=0, push 10, 20, 30 on consecutive cycles -> `ptr_addr_wr_o` steps 1, 2, 3.
- Drain: `ctrl_tx_buffer`=1, then `done_tx` pulses, each 1 cycle high:
  - Registered mode -> `wr_data_o` 10 then 20, and `ptr_addr_wr_o` stays 3.
  - FWFT mode -> `wr_data_o` 10 before the first pop, then 20, then 30.
- Full level: `ptr_addr_wr_i`=4, attempt 6 pushes -> `ptr_addr_wr_o`=4, extra bytes dropped.
  - With `ptr_addr_wr_i`=0: 33 pushes -> `ptr_addr_wr_o` wraps to 0 after the 32nd push and the 33rd push is dropped.
- Flush: with 3 entries, `rx_state_full`=1 for one cycle while `done_tx`=1 -> `ptr_addr_wr_o`=0 and the FIFO is empty. A subsequent `done_tx` causes no pop.
- Gating: `tx_buffer_overrun`=1 or `fifo_en`=0 with `wr_data`=40 driven for 3 cycles -> no pointer change.
